// File: rtl/tick_scheduler.sv
// tick_scheduler: shared timebase. One prescaler produces base_tick every
// BASE_DIV clk; NCH channels divide base_tick by a runtime period and emit
// one-cycle tick strobes. Channels are configured through a valid/ready port.
// Optional build macro: TICK_ONESHOT_EN adds cfg_oneshot (single-tick channels).
module tick_scheduler #(
  parameter int unsigned BASE_DIV = 50000,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_enable,
`ifdef TICK_ONESHOT_EN
  input  logic             cfg_oneshot,
`endif
  output logic             cfg_err,
  output logic             base_tick,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   ch_active
);

  localparam int unsigned CH_W   = 2;
  localparam int unsigned PCNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               accept_c;
  logic               apply_c;

  logic [PCNT_W-1:0]  pcnt_q;

  logic [CH_W-1:0]    lat_ch;
  logic [CNT_W-1:0]   lat_period;
  logic               lat_enable;
  logic               lat_oneshot;

  logic [CNT_W-1:0]   period_q [NCH];
  logic [CNT_W-1:0]   cnt_q    [NCH];
  logic [NCH-1:0]     oneshot_q;

  // Prescaler: pcnt wraps at BASE_DIV-1 and base_tick strobes on that edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      base_tick <= 1'b0;
    end else if (pcnt_q == PCNT_W'(BASE_DIV - 1)) begin
      pcnt_q    <= '0;
      base_tick <= 1'b1;
    end else begin
      pcnt_q    <= pcnt_q + PCNT_W'(1);
      base_tick <= 1'b0;
    end
  end

  // Config FSM next-state: accept in IDLE, spend exactly one cycle in APPLY
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          accept_c = 1'b1;
          state_d  = S_APPLY;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign apply_c = (state_q == S_APPLY);

  // Config FSM state register; cfg_ready registered from next state so it
  // stays low through reset and rises on the first released edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cfg_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_ready <= (state_d == S_IDLE);
    end
  end

  // Capture the write payload at the handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_ch     <= '0;
      lat_period <= '0;
      lat_enable <= 1'b0;
    end else if (accept_c) begin
      lat_ch     <= cfg_ch;
      lat_period <= cfg_period;
      lat_enable <= cfg_enable;
    end
  end

`ifdef TICK_ONESHOT_EN
  // Capture the oneshot flag alongside the rest of the payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_oneshot <= 1'b0;
    end else if (accept_c) begin
      lat_oneshot <= cfg_oneshot;
    end
  end
`else
  assign lat_oneshot = 1'b0;
`endif

  // Channel counters: a config write to a channel overrides its base-tick
  // evaluation on the same edge; other channels evaluate normally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      oneshot_q <= '0;
      tick      <= '0;
      ch_active <= '0;
      cfg_err   <= 1'b0;
    end else begin
      tick    <= '0;
      cfg_err <= apply_c && lat_enable && (lat_period == '0);
      for (int unsigned i = 0; i < NCH; i++) begin
        if (apply_c && (lat_ch == CH_W'(i))) begin
          period_q[i]  <= lat_period;
          cnt_q[i]     <= lat_period - CNT_W'(1);
          ch_active[i] <= lat_enable && (lat_period != '0);
          oneshot_q[i] <= lat_oneshot;
        end else if (base_tick && ch_active[i]) begin
          if (cnt_q[i] == '0) begin
            tick[i]  <= 1'b1;
            cnt_q[i] <= period_q[i] - CNT_W'(1);
            if (oneshot_q[i]) begin
              ch_active[i] <= 1'b0;
            end
          end else begin
            cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (BASE_DIV=4). The reference model predicts each
// channel's tick as an absolute edge number: after a write applied on edge a
// with period p, the first tick is on the p-th base-tick evaluation edge
// strictly after a, then every p*BASE_DIV edges.
module tb_tick_scheduler;

  localparam int unsigned B     = 4;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 16;
`ifdef TICK_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             cfg_enable = 1'b0;
  logic             os_drv = 1'b0;
  logic             cfg_err;
  logic             base_tick;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   ch_active;

  tick_scheduler #(.BASE_DIV(B), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_enable (cfg_enable),
`ifdef TICK_ONESHOT_EN
    .cfg_oneshot(os_drv),
`endif
    .cfg_err    (cfg_err),
    .base_tick  (base_tick),
    .tick       (tick),
    .ch_active  (ch_active)
  );

  always #5 clk = ~clk;

  // Model state
  int             n_cmp = 0;
  int             n_bad = 0;
  int             edge_n = 0;
  bit             m_ready = 1'b0;
  bit             m_err = 1'b0;
  bit             hs = 1'b0;
  bit             pend = 1'b0;
  int             p_ch, p_per;
  bit             p_en, p_os;
  bit             act [NCH];
  bit             os  [NCH];
  int             per [NCH];
  longint         nxt [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_act;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n  = 0;
    m_ready = 1'b0;
    pend    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      act[c] = 1'b0;
      os[c]  = 1'b0;
      per[c] = 0;
      nxt[c] = 0;
    end
  endtask

  // Advance one clock, update the model from the pre-edge inputs, compare
  task automatic step();
    bit rs, v;
    @(posedge clk);
    rs     = rst_n;
    v      = cfg_valid;
    m_tick = '0;
    m_err  = 1'b0;
    hs     = 1'b0;
    if (!rs) begin
      model_reset();
    end else begin
      edge_n++;
      if (pend) begin
        pend       = 1'b0;
        act[p_ch]  = p_en && (p_per != 0);
        os[p_ch]   = p_os;
        per[p_ch]  = p_per;
        m_err      = p_en && (p_per == 0);
        nxt[p_ch]  = (longint'((edge_n - 1) / B) + longint'(p_per)) * B + 1;
      end
      for (int c = 0; c < NCH; c++) begin
        if (act[c] && nxt[c] == longint'(edge_n)) begin
          m_tick[c] = 1'b1;
          nxt[c]    = nxt[c] + longint'(per[c]) * B;
          if (os[c]) act[c] = 1'b0;
        end
      end
      hs = v && m_ready;
      if (hs) begin
        pend  = 1'b1;
        p_ch  = int'(cfg_ch);
        p_per = int'(cfg_period);
        p_en  = cfg_enable;
        p_os  = ONESHOT && os_drv;
      end
      m_ready = !hs;
    end
    for (int c = 0; c < NCH; c++) m_act[c] = act[c];
    #1;
    chk("base_tick", 32'(base_tick), 32'(edge_n > 0 && (edge_n % B) == 0));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    chk("cfg_err",   32'(cfg_err),   32'(m_err));
    chk("tick",      32'(tick),      32'(m_tick));
    chk("ch_active", 32'(ch_active), 32'(m_act));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Present a write and hold it stable until the handshake edge
  task automatic cfg_write(input int ch, input int p, input bit en, input bit os1);
    int guard = 0;
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = CNT_W'(p);
    cfg_enable = en;
    os_drv     = os1;
    do begin
      step();
      guard++;
    end while (!hs && guard < 8);
    if (!hs) chk("handshake_timeout", 32'(0), 32'(1));
    cfg_valid = 1'b0;
    os_drv    = 1'b0;
  endtask

  initial begin
    int t, ch, p, gap, sel;
    bit en, os1;
    model_reset();

    // Reset, release, base_tick cadence
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(13);

    // ch0 period 3
    cfg_write(0, 3, 1'b1, 1'b0);
    run(40);

    // Back-to-back writes ch1 p=1, ch2 p=2
    cfg_write(1, 1, 1'b1, 1'b0);
    cfg_write(2, 2, 1'b1, 1'b0);
    run(24);

    // Enable with period 0 flags an error; disable with period 0 is silent
    cfg_write(0, 0, 1'b1, 1'b0);
    run(3);
    cfg_write(0, 0, 1'b0, 1'b0);
    run(3);
    cfg_write(0, 3, 1'b1, 1'b0);
    run(6);

    // ch3 period 2, then rewrite so APPLY lands on its pending tick edge
    cfg_write(3, 2, 1'b1, 1'b0);
    run(10);
    t = int'(nxt[3]);
    while (t < edge_n + 3) t += per[3] * B;
    while (edge_n < t - 2) step();
    cfg_write(3, 2, 1'b1, 1'b0);
    run(24);

    // Short reset mid-count: everything clears and stays quiet
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(30);

    // Maximum period: reload fits in CNT_W, no early tick
    cfg_write(1, 65535, 1'b1, 1'b0);
    cfg_write(2, 1, 1'b1, 1'b0);
    run(40);

    if (ONESHOT) begin
      cfg_write(2, 5, 1'b1, 1'b1);
      run(50);
    end

    // Randomized writes, with occasional short resets
    for (int it = 0; it < 200; it++) begin
      gap = int'($urandom_range(0, 6));
      run(gap);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
      end
      ch  = int'($urandom_range(0, NCH - 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      p = 0;
      else if (sel == 1) p = 65535;
      else if (sel < 6)  p = int'($urandom_range(1, 4));
      else               p = int'($urandom_range(1, 20));
      en  = ($urandom_range(0, 9) != 0);
      os1 = ($urandom_range(0, 3) == 0);
      cfg_write(ch, p, en, os1);
    end
    run(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shared timebase controller for the calculator.
- One prescaler divides clk to a base tick (1 kHz at 50 MHz). NCH channels each hold a runtime-programmable period in base ticks and emit one-cycle enable strobes.
- Replaces per-consumer free-running divided clocks (display scan, key debounce, cursor blink) with single-clock-domain strobes.
- Configured by the control logic through a valid/ready write port.

Parameters:
- BASE_DIV, 50000, clk cycles per base tick (must be >= 2).
- NCH, 4, number of tick channels (fixed; cfg_ch width 2).
- CNT_W, 16, width of period and channel counters.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous reset, active-low.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  scheduler can accept a config write.
- cfg_ch  in  2  target channel index.
- cfg_period  in  CNT_W  tick period in base ticks.
- cfg_enable  in  1  channel enable.
- cfg_err  out  1  one-cycle pulse: accepted write had enable=1 with period=0.
- base_tick  out  1  one-cycle strobe per BASE_DIV clk.
- tick  out  NCH  per-channel one-cycle strobes.
- ch_active  out  NCH  current enable state of each channel.

Behaviour:
- Reset: sampled on posedge clk while rst_n=0. Sets:
  - base_tick=0, tick=0, cfg_err=0, ch_active=0, cfg_ready=0;
  - prescaler count=0, all periods/counters=0, FSM=IDLE.
- cfg_ready rises on the first clk edge with rst_n=1.
- Reset mid-operation discards any pending write and aborts all counts.
- Prescaler:
  - pcnt counts 0..BASE_DIV-1 and wraps to 0.
  - base_tick<=1 on the edge where pcnt==BASE_DIV-1, else 0.
  - First base_tick is high BASE_DIV cycles after reset release.
- Channel i, evaluated on the edge where registered base_tick==1:
  - if ch_active[i] and cnt[i]==0: tick[i]<=1 and cnt[i]<=period[i]-1;
  - if ch_active[i] and cnt[i]!=0: cnt[i]<=cnt[i]-1;
  - disabled channels hold cnt and never tick.
  - tick[i] is 0 on all other edges.
  - Latency: tick[i] goes high one clk after the base_tick it is derived from.
  - Steady-state spacing is period[i]*BASE_DIV clk.
- Config FSM, 2 states:
  - IDLE: cfg_ready=1. On cfg_valid&&cfg_ready, latch cfg_ch/cfg_period/cfg_enable and go to APPLY.
  - APPLY: cfg_ready=0, one cycle. Write period[ch]; cnt[ch]<=cfg_period-1; ch_active[ch]<=cfg_enable&&(cfg_period!=0); cfg_err<=cfg_enable&&(cfg_period==0). Return to IDLE.
  - Throughput is one write per 2 clk.
  - cfg_valid held high while in APPLY is not a second write. Master must keep valid/data stable until the handshake.
- Boundaries:
  - APPLY coincides with base_tick evaluation of the same channel: config wins. No tick for that channel on that base tick; cnt loads cfg_period-1. Other channels evaluate normally.
  - period=1: tick on every base tick.
  - period=2^CNT_W-1: counter wraps correctly, with no overflow (reload fits in CNT_W).
  - Disabling a channel whose tick is already registered does not cancel that strobe.
  - Re-enabling restarts phase: the first tick comes on the cfg_period-th base_tick after APPLY.
  - period=0 with enable=0: accepted silently (no cfg_err); channel disabled.

Optional Feature:
- Macro TICK_ONESHOT_EN.
- Defined:
  - adds input port cfg_oneshot (1 bit), latched with the write;
  - a channel written with cfg_oneshot=1 emits exactly one tick, then clears ch_active[i] on the same edge it asserts tick[i];
  - periodic channels are unchanged.
- Undefined: port absent; all channels periodic.

Test Plan:
- Reset release with BASE_DIV=4 -> base_tick high on clk 4, 8, 12 after release; tick=0; cfg_ready=1 from clk 1.
- Write ch0 period=3 enable=1 -> tick[0] pulses one clk after every 3rd base_tick, 12 clk apart; cfg_ready low exactly 1 cycle.
- Write ch1 period=1 and ch2 period=2 back-to-back -> tick[1] every base tick, tick[2] every 2nd; writes take 4 clk total.
- Write ch0 enable=1 period=0 -> cfg_err pulses 1 cycle, ch_active[0]=0, no tick[0]; write period=0 enable=0 -> no cfg_err.
- APPLY aligned with a base_tick where cnt[3]==0 (ch3 period=2) -> tick[3] suppressed, next tick[3] after 2 base ticks; tick[0] unaffected.
- rst_n low for 1 clk mid-count with 3 active channels -> all outputs 0 on the next edge; no tick until reprogrammed. With TICK_ONESHOT_EN: oneshot ch2 period=5 -> single tick[2] at 5th base tick, then ch_active[2]=0.
